serial_parallel_rx: RTL and testbench
=====================================

# serial_parallel_rx

Parametrised serial-to-parallel receiver, the successor to the lab 4 receive path. It recovers asynchronous frames from a single line: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit. It uses an internal oversampling counter, not a separate bit clock. Each received character is held in a one-entry output register and handed to the CPU side through a valid/ready handshake, with framing, parity and overrun status.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clk cycles per bit period; legal ≥4, even; HALF = CLKS_PER_BIT/2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only when parity is compiled in.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-low.
- fromSerial  input  1  asynchronous serial line, idle high.
- ready  input  1  CPU accepts the held character this cycle.
- dataToCPU  output  DATA_BITS  held character.
- charReceived  output  1  valid: dataToCPU, frameErr and parityErr are meaningful.
- frameErr  output  1  held character had stop bit = 0.
- parityErr  output  1  held character failed the parity check (always 0 without parity).
- overrun  output  1  sticky: a frame completed while charReceived=1 and ready=0.
- busy  output  1  FSM is not in IDLE.

## Operation
- fromSerial passes through a 2-flop synchroniser; all references below use the synchronised line `rx`.
- FSM states are IDLE, START, DATA, PARITY (only when compiled in), STOP and WAIT_HIGH.
- **IDLE:** rx=0 → go to START, clear the bit counter, load the clock counter. Call this cycle t0.
- **START:** at t0+HALF, sample rx.
  - rx=1 → glitch; go to IDLE, nothing is reported.
  - rx=0 → go to DATA.
- **DATA:** sample bit i (i=0..DATA_BITS-1) at t0+HALF+(i+1)·CLKS_PER_BIT. Shift right into a DATA_BITS shift register, so the first bit received ends up as the LSB.
- **PARITY:** sample at t0+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - Error when XOR(data, parity bit) ≠ PARITY_ODD.
- **STOP:** sample one bit period after the last data or parity sample.
  - rx=1 → go to IDLE in the next cycle. A new start bit may be detected immediately.
  - rx=0 → set frameErr for this frame; go to WAIT_HIGH.
- **WAIT_HIGH:** stay until rx=1, then go to IDLE. A break condition must not produce repeated frames.
- **Frame completion** (at the stop sample):
  - If the holding register is empty, or is being emptied this same cycle (charReceived & ready), load dataToCPU, frameErr and parityErr, and set charReceived.
  - Otherwise drop the new frame, keep the old contents, and set overrun.
- **Handshake:** when charReceived & ready, clear charReceived in the next cycle. dataToCPU holds its value until the next load.
- **overrun:** cleared by the first accepted handshake after it was set. If a new overrun occurs in that same cycle, overrun stays set.
- **Reset** (reset=0 at a posedge), including mid-frame:
  - FSM goes to IDLE; counters and shift register go to 0; synchroniser flops go to 1.
  - dataToCPU=0; charReceived, frameErr, parityErr, overrun and busy all go to 0.
  - A partial frame is discarded.

## Timing
- Input latency: a line edge reaches `rx` after 2 clk.
- Stop sample at ts = t0+HALF+(DATA_BITS+1+P)·CLKS_PER_BIT, where P = 1 if parity is compiled in, else 0.
- charReceived rises at ts+1.
- With defaults and no parity: ts = t0+152, so charReceived rises at t0+153.
- busy is 1 from t0+1 through ts (and through WAIT_HIGH).
- Back-to-back frames: the next start bit can be detected at ts+1.
- Throughput is one character per frame period. No bubble is required if ready is held high.
- ready while charReceived=0 is ignored.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present and P=1.
  - parityErr reflects the check for each frame.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; the stop bit follows the last data bit.
  - parityErr is tied to 0.
  - PARITY_ODD is ignored.

## Test plan
- Defaults, no parity, ready=1; send 0xA5 with a valid stop bit → dataToCPU=0xA5 and charReceived=1 at t0+153; frameErr=0; the handshake clears charReceived at t0+154.
- Drive a low pulse of 4 clk while idle → START samples rx=1 and returns to IDLE; charReceived never asserts; busy drops after t0+8.
- Send 0x3C with stop bit = 0, then hold the line low for 40 clk → charReceived=1 with frameErr=1 and data 0x3C; no second frame while low; IDLE only after the line returns high.
- ready=0; send 0x11 then 0x22 back-to-back → dataToCPU stays 0x11 and overrun=1 after the second stop sample; pulsing ready clears charReceived and overrun.
- UART_RX_PARITY_EN, PARITY_ODD=0; send 0x07 with parity bit 1, then 0x07 with parity bit 0 → parityErr=0 on the first frame and 1 on the second.
- Assert reset=0 for one cycle at t0+70 during frame 0x5A → all outputs are 0 on the next cycle; no character is delivered; a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/serial_parallel_rx_if.sv
// CPU-side bundle of the serial receiver: the serial line in, plus the held character,
// its status flags and the valid/ready handshake.
interface serial_parallel_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 fromSerial;
  logic                 ready;
  logic [DATA_BITS-1:0] dataToCPU;
  logic                 charReceived;
  logic                 frameErr;
  logic                 parityErr;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  fromSerial, ready,
    output dataToCPU, charReceived, frameErr, parityErr, overrun, busy
  );

  modport slave (
    output fromSerial, ready,
    input  dataToCPU, charReceived, frameErr, parityErr, overrun, busy
  );
endinterface

// File: rtl/serial_parallel_rx.sv
// Oversampling asynchronous frame receiver with a one-entry valid/ready output register.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module serial_parallel_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_parallel_rx_if.master bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
    parity_fail = ((^d) ^ p) != PARITY_ODD[0];
  endfunction

  state_t               r_state;
  logic                 r_sync1, r_rx;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_perr, r_ovr, r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
`endif

  logic w_accept, w_tick, w_perr;
  assign w_accept = r_valid & bus.ready;
  assign w_tick   = (r_cnt == '0);
`ifdef UART_RX_PARITY_EN
  assign w_perr   = parity_fail(r_shift, r_par);
`else
  assign w_perr   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b1;
      r_rx     <= 1'b1;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.fromSerial;
      r_rx    <= r_sync1;
      if (w_accept) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rx) begin
            r_state  <= S_START;
            r_bitcnt <= '0;
            r_cnt    <= CW'(HALF - 1);
            r_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_rx) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_DATA;
            r_cnt   <= CW'(CLKS_PER_BIT - 1);
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {r_rx, r_shift[DATA_BITS-1:1]};
            r_cnt   <= CW'(CLKS_PER_BIT - 1);
            if (r_bitcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_par   <= r_rx;
            r_state <= S_STOP;
            r_cnt   <= CW'(CLKS_PER_BIT - 1);
          end
        end
`endif
        S_STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // A full register that is not being drained this cycle loses the new frame.
            if (!r_valid || w_accept) begin
              r_data  <= r_shift;
              r_ferr  <= ~r_rx;
              r_perr  <= w_perr;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
            if (r_rx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataToCPU    = r_data;
  assign bus.charReceived = r_valid;
  assign bus.frameErr     = r_ferr;
  assign bus.parityErr    = r_perr;
  assign bus.overrun      = r_ovr;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: table of frames plus timing, glitch, break,
// overrun and mid-frame reset sequences.
module tb_serial_parallel_rx;
  localparam int DB  = 8;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_parallel_rx_if #(.DATA_BITS(DB)) bus();

  serial_parallel_rx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge monitor on the opposite clock edge, stamped with the posedge count.
  logic cr_q = 1'b0, busy_q = 1'b0;
  int cr_rises = 0, cr_rise_cyc = 0, cr_fall_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  always @(negedge clk) begin
    if (bus.charReceived && !cr_q) begin
      cr_rises    = cr_rises + 1;
      cr_rise_cyc = cyc;
    end
    if (!bus.charReceived && cr_q) cr_fall_cyc = cyc;
    if (bus.busy && !busy_q) busy_rise_cyc = cyc;
    if (!bus.busy && busy_q) busy_fall_cyc = cyc;
    cr_q   = bus.charReceived;
    busy_q = bus.busy;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level; callers restore idle after a break.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    bus.fromSerial = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      bus.fromSerial = d[i];
      tick(CPB);
    end
    if (PAR_EN != 0) begin
      bus.fromSerial = par;
      tick(CPB);
    end
    bus.fromSerial = stop;
    tick(CPB);
  endtask

  task automatic accept();
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       ferr;
    logic       perr;
  } vec_t;

  vec_t vt[7];

  initial begin
    int e;
    int r0;
    vt[0] = '{d: 8'hA5, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vt[1] = '{d: 8'h00, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vt[2] = '{d: 8'hFF, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vt[3] = '{d: 8'h01, par: 1'b1, stop: 1'b0, ferr: 1'b1, perr: 1'b0};
    vt[4] = '{d: 8'h07, par: 1'b1, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vt[5] = '{d: 8'h07, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b1};
    vt[6] = '{d: 8'h80, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b1};

    bus.fromSerial = 1'b1;
    bus.ready      = 1'b0;
    tick(3);
    check("rst_data", 32'(bus.dataToCPU), 32'h0);
    check("rst_valid", 32'(bus.charReceived), 32'h0);
    check("rst_ferr", 32'(bus.frameErr), 32'h0);
    check("rst_perr", 32'(bus.parityErr), 32'h0);
    check("rst_ovr", 32'(bus.overrun), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    tick(4);

    // 0xA5 with ready held high: exact latency of valid, handshake and busy.
    e  = cyc;
    r0 = cr_rises;
    bus.ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(2);
    bus.ready = 1'b0;
    check("a5_rises", 32'(cr_rises - r0), 32'd1);
    check("a5_rise_cyc", 32'(cr_rise_cyc - e), 32'(155 + PAR_EN * CPB));
    check("a5_fall_cyc", 32'(cr_fall_cyc - e), 32'(156 + PAR_EN * CPB));
    check("a5_busy_rise", 32'(busy_rise_cyc - e), 32'd3);
    check("a5_busy_fall", 32'(busy_fall_cyc - e), 32'(155 + PAR_EN * CPB));
    check("a5_data", 32'(bus.dataToCPU), 32'hA5);
    check("a5_ferr", 32'(bus.frameErr), 32'h0);

    // Four-clock low glitch while idle.
    e  = cyc;
    r0 = cr_rises;
    bus.fromSerial = 1'b0;
    tick(4);
    bus.fromSerial = 1'b1;
    tick(30);
    check("glitch_rises", 32'(cr_rises - r0), 32'd0);
    check("glitch_busy_rise", 32'(busy_rise_cyc - e), 32'd3);
    check("glitch_busy_fall", 32'(busy_fall_cyc - e), 32'd11);

    // Table of frames, each drained by a one-cycle ready pulse.
    for (int k = 0; k < 7; k++) begin
      send_frame(vt[k].d, vt[k].par, vt[k].stop);
      bus.fromSerial = 1'b1;
      tick(1);
      check($sformatf("vec%0d_valid", k), 32'(bus.charReceived), 32'h1);
      check($sformatf("vec%0d_data", k), 32'(bus.dataToCPU), 32'(vt[k].d));
      check($sformatf("vec%0d_ferr", k), 32'(bus.frameErr), 32'(vt[k].ferr));
      check($sformatf("vec%0d_perr", k), 32'(bus.parityErr), (PAR_EN != 0) ? 32'(vt[k].perr) : 32'h0);
      check($sformatf("vec%0d_ovr", k), 32'(bus.overrun), 32'h0);
      accept();
      check($sformatf("vec%0d_clear", k), 32'(bus.charReceived), 32'h0);
      tick(5);
    end

    // Break: bad stop bit, then line held low for 40 clocks.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("brk_valid", 32'(bus.charReceived), 32'h1);
    check("brk_data", 32'(bus.dataToCPU), 32'h3C);
    check("brk_ferr", 32'(bus.frameErr), 32'h1);
    accept();
    r0 = cr_rises;
    tick(40);
    check("brk_no_repeat", 32'(cr_rises - r0), 32'd0);
    check("brk_busy_low", 32'(bus.busy), 32'h1);
    bus.fromSerial = 1'b1;
    tick(4);
    check("brk_idle", 32'(bus.busy), 32'h0);
    check("brk_valid_after", 32'(bus.charReceived), 32'h0);
    tick(10);

    // Overrun: two frames back-to-back with ready low.
    send_frame(8'h11, 1'b0, 1'b1);
    check("ovr_first_valid", 32'(bus.charReceived), 32'h1);
    check("ovr_first_flag", 32'(bus.overrun), 32'h0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("ovr_data_kept", 32'(bus.dataToCPU), 32'h11);
    check("ovr_valid", 32'(bus.charReceived), 32'h1);
    check("ovr_flag", 32'(bus.overrun), 32'h1);
    accept();
    check("ovr_valid_clr", 32'(bus.charReceived), 32'h0);
    check("ovr_flag_clr", 32'(bus.overrun), 32'h0);
    check("ovr_data_hold", 32'(bus.dataToCPU), 32'h11);
    tick(10);

    // Reset pulse in the middle of 0x5A (bits 0..2 sent, bit 3 high on the line).
    e  = cyc;
    bus.fromSerial = 1'b0;
    tick(CPB);
    bus.fromSerial = 1'b0; tick(CPB);
    bus.fromSerial = 1'b1; tick(CPB);
    bus.fromSerial = 1'b0; tick(CPB);
    bus.fromSerial = 1'b1;
    tick(8);
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    tick(1);
    check("mid_rst_cyc", 32'(cyc - e), 32'd73);
    check("mid_rst_data", 32'(bus.dataToCPU), 32'h0);
    check("mid_rst_valid", 32'(bus.charReceived), 32'h0);
    check("mid_rst_ferr", 32'(bus.frameErr), 32'h0);
    check("mid_rst_perr", 32'(bus.parityErr), 32'h0);
    check("mid_rst_ovr", 32'(bus.overrun), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    r0 = cr_rises;
    tick(200);
    check("mid_no_char", 32'(cr_rises - r0), 32'd0);
    check("mid_idle", 32'(bus.busy), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1);
    check("post_valid", 32'(bus.charReceived), 32'h1);
    check("post_data", 32'(bus.dataToCPU), 32'h81);
    check("post_ferr", 32'(bus.frameErr), 32'h0);
    accept();
    check("post_clear", 32'(bus.charReceived), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
